// File: rtl/ram_strcpy_ctrl.sv
// ---------------------------------------------------------------------------
// ram_strcpy_ctrl
//
// Copies a nul-terminated string of RAM words from src_addr to dst_addr,
// one word per READ/WRITE pair, and shares the single RAM port with a host.
// The host owns the RAM port in IDLE and DONE and is stalled in READ/WRITE.
//
// Parameters
//   AW        RAM address width
//   DW        RAM word width
//   MAX_WORDS maximum words copied per operation, terminator included
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start, src_addr, dst_addr  copy request (sampled only in IDLE)
//   busy, done                 copy in progress / one-cycle completion pulse
//   host_we/addr/wdata/rdata   host RAM access path
//   host_stall                 host access blocked this cycle
//   ram_we/addr/wdata/rdata    RAM port (asynchronous read data)
//   copy_count                 words written by the last copy
//                              (only with RAM_STRCPY_COUNT_EN defined)
// ---------------------------------------------------------------------------
module ram_strcpy_ctrl #(
    parameter int AW        = 10,
    parameter int DW        = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    output logic          busy,
    output logic          done,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_stall,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
`ifdef RAM_STRCPY_COUNT_EN
    output logic [AW:0]   copy_count,
`endif
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_WORDS);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_inc;
    logic [DW-1:0] data_reg;
    logic          last_word;

    assign cnt_inc   = cnt + {{AW{1'b0}}, 1'b1};
    // The word being written is the last one if it is the terminator or
    // if it exhausts the per-operation word budget.
    assign last_word = (data_reg == '0) || (cnt_inc == MAX_CNT);

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            data_reg <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        cnt     <= '0;
                    end
                end
                READ: begin
                    data_reg <= ram_rdata;
                end
                WRITE: begin
                    // Pointers wrap naturally at 2^AW.
                    if (!last_word) begin
                        src_ptr <= src_ptr + {{(AW-1){1'b0}}, 1'b1};
                        dst_ptr <= dst_ptr + {{(AW-1){1'b0}}, 1'b1};
                        cnt     <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RAM_STRCPY_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            copy_count <= '0;
        end else if (state == WRITE && last_word) begin
            copy_count <= cnt_inc;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = last_word ? DONE : READ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs and RAM port arbitration
    // -----------------------------------------------------------------------
    // While reset is asserted the RAM write enable is held low so an aborted
    // copy (or anything else) cannot disturb memory in the reset cycle, and
    // the status outputs already show the idle values.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        host_stall = 1'b0;
        ram_we     = host_we & ~reset;
        ram_addr   = host_addr;
        ram_wdata  = host_wdata;
        if (!reset) begin
            case (state)
                READ: begin
                    busy       = 1'b1;
                    host_stall = 1'b1;
                    ram_we     = 1'b0;
                    ram_addr   = src_ptr;
                end
                WRITE: begin
                    busy       = 1'b1;
                    host_stall = 1'b1;
                    ram_we     = 1'b1;
                    ram_addr   = dst_ptr;
                    ram_wdata  = data_reg;
                end
                DONE:    done = 1'b1;
                default: ;
            endcase
        end
    end

    assign host_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_strcpy_ctrl.sv
module tb_ram_strcpy_ctrl;

    localparam int AW = 10;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          busy;
    logic          done;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_stall;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW:0]   copy_count;

    // Second instance with a 4-word budget
    logic          start4;
    logic [AW-1:0] src4;
    logic [AW-1:0] dst4;
    logic          busy4;
    logic          done4;
    logic [DW-1:0] host_rdata4;
    logic          host_stall4;
    logic          ram_we4;
    logic [AW-1:0] ram_addr4;
    logic [DW-1:0] ram_wdata4;
    logic [DW-1:0] ram_rdata4;
    logic [AW:0]   copy_count4;

    logic [DW-1:0] mem  [0:1023];
    logic [DW-1:0] mem4 [0:1023];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ram_strcpy_ctrl #(.AW(AW), .DW(DW), .MAX_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .busy(busy), .done(done),
        .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_stall(host_stall),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef RAM_STRCPY_COUNT_EN
        .copy_count(copy_count),
`endif
        .ram_rdata(ram_rdata)
    );

    ram_strcpy_ctrl #(.AW(AW), .DW(DW), .MAX_WORDS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .src_addr(src4), .dst_addr(dst4),
        .busy(busy4), .done(done4),
        .host_we(1'b0), .host_addr('0), .host_wdata('0),
        .host_rdata(host_rdata4), .host_stall(host_stall4),
        .ram_we(ram_we4), .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
`ifdef RAM_STRCPY_COUNT_EN
        .copy_count(copy_count4),
`endif
        .ram_rdata(ram_rdata4)
    );

`ifndef RAM_STRCPY_COUNT_EN
    assign copy_count  = '0;
    assign copy_count4 = '0;
`endif

    // RAM models: asynchronous read, synchronous write
    assign ram_rdata  = mem[ram_addr];
    assign ram_rdata4 = mem4[ram_addr4];

    always @(posedge clk) begin
        if (ram_we)  mem[ram_addr]   <= ram_wdata;
        if (ram_we4) mem4[ram_addr4] <= ram_wdata4;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle, then counts cycles until done (bounded).
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, output int n);
        src_addr = s;
        dst_addr = d;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (!done) n = -1;
    endtask

    int n;
    int done_seen;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  <= '0;
            mem4[i] <= '0;
        end
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0;
        host_we = 1'b0; host_addr = '0; host_wdata = '0;
        start4 = 1'b0; src4 = '0; dst4 = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_stall", {31'b0, host_stall}, 0);
        check("rst_count", {21'b0, copy_count}, 0);

        // Two characters plus nul
        mem[6] <= 10'h057; mem[7] <= 10'h061; mem[8] <= 10'h000;
        mem[602] <= 10'h155;
        tick();
        host_addr = 6;
        #1;
        check("idle_rdata", {22'b0, host_rdata}, 32'h057);
        run_copy(6, 600, n);
        check("t1_latency", n, 7);
        check("t1_w0", {22'b0, mem[600]}, 32'h057);
        check("t1_w1", {22'b0, mem[601]}, 32'h061);
        check("t1_w2", {22'b0, mem[602]}, 32'h000);
`ifdef RAM_STRCPY_COUNT_EN
        check("t1_count", {21'b0, copy_count}, 3);
`endif
        tick();
        check("t1_done_pulse", {31'b0, done}, 0);

        // Empty string: only the terminator
        mem[5] <= 10'h000; mem[700] <= 10'h155;
        tick();
        run_copy(5, 700, n);
        check("t2_latency", n, 3);
        check("t2_w0", {22'b0, mem[700]}, 0);
`ifdef RAM_STRCPY_COUNT_EN
        check("t2_count", {21'b0, copy_count}, 1);
`endif

        // Source pointer wraps from 1023 to 0
        mem[1022] <= 10'h041; mem[1023] <= 10'h042; mem[0] <= 10'h000;
        mem[100] <= 10'h3FF; mem[101] <= 10'h3FF; mem[102] <= 10'h3FF;
        tick();
        run_copy(1022, 100, n);
        check("t3_latency", n, 7);
        check("t3_w0", {22'b0, mem[100]}, 32'h041);
        check("t3_w1", {22'b0, mem[101]}, 32'h042);
        check("t3_w2", {22'b0, mem[102]}, 32'h000);

        // Host write blocked while busy; start during busy is not queued
        for (int i = 0; i < 5; i++) mem[200+i] <= 10'(i + 1);
        mem[205] <= 10'h000;
        mem[50]  <= 10'h011;
        tick();
        src_addr = 200; dst_addr = 300; start = 1'b1;
        tick();
        start = 1'b0;
        host_we = 1'b1; host_addr = 50; host_wdata = 10'h3FF;
        #1;
        check("t4_busy", {31'b0, busy}, 1);
        check("t4_stall", {31'b0, host_stall}, 1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        host_we = 1'b0;
        n = 0;
        while (!done && n < 200) begin tick(); n++; end
        check("t4_done_seen", {31'b0, done}, 1);
        check("t4_blocked", {22'b0, mem[50]}, 32'h011);
        check("t4_copy_last", {22'b0, mem[304]}, 5);
        tick(); tick();
        check("t4_no_restart", {31'b0, busy}, 0);
        host_we = 1'b1; host_addr = 50; host_wdata = 10'h3FF;
        #1;
        check("t4_idle_stall", {31'b0, host_stall}, 0);
        tick();
        host_we = 1'b0;
        #1;
        check("t4_idle_write", {22'b0, mem[50]}, 32'h3FF);
        check("t4_rdata", {22'b0, host_rdata}, 32'h3FF);

        // Reset in the 4th cycle of a 10-word copy
        for (int i = 0; i < 10; i++) begin
            mem[400+i] <= 10'(i + 16);
            mem[500+i] <= '0;
        end
        mem[410] <= 10'h000;
        tick();
        src_addr = 400; dst_addr = 500; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("t5_we_in_rst", {31'b0, ram_we}, 0);
        tick();
        reset = 1'b0;
        #1;
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_first_word", {22'b0, mem[500]}, 16);
        check("t5_aborted_word", {22'b0, mem[501]}, 0);
        check("t5_count_clr", {21'b0, copy_count}, 0);
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("t5_no_done", done_seen, 0);
        check("t5_no_more_writes", {22'b0, mem[502]}, 0);

        // No terminator within the 4-word budget
        for (int i = 0; i < 8; i++) mem4[10+i] <= 10'(i + 32);
        tick();
        src4 = 10; dst4 = 30; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 1;
        while (!done4 && n < 200) begin tick(); n++; end
        check("t6_latency", n, 9);
        for (int i = 0; i < 4; i++) check("t6_word", {22'b0, mem4[30+i]}, 32'(i + 32));
        check("t6_no_extra", {22'b0, mem4[34]}, 0);
`ifdef RAM_STRCPY_COUNT_EN
        check("t6_count", {21'b0, copy_count4}, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ram_strcpy_ctrl.md
RAM_STRCPY_CTRL -- requirements
Module: ram_strcpy_ctrl

Interface
REQ-001 SHALL have parameter AW, default 10, RAM address width.
REQ-002 SHALL have parameter DW, default 10, RAM word width.
REQ-003 SHALL have parameter MAX_WORDS, default 1024, maximum words copied per operation, terminator included.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  copy request, sampled only in IDLE.
REQ-007 SHALL have port src_addr  input  AW  first source word address.
REQ-008 SHALL have port dst_addr  input  AW  first destination word address.
REQ-009 SHALL have port busy  output  1  high in READ and WRITE.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port host_we  input  1  host write enable.
REQ-012 SHALL have port host_addr  input  AW  host address.
REQ-013 SHALL have port host_wdata  input  DW  host write data.
REQ-014 SHALL have port host_rdata  output  DW  host read data.
REQ-015 SHALL have port host_stall  output  1  host access is blocked this cycle.
REQ-016 SHALL have port ram_we  output  1  RAM write enable.
REQ-017 SHALL have port ram_addr  output  AW  RAM address.
REQ-018 SHALL have port ram_wdata  output  DW  RAM write data.
REQ-019 SHALL have port ram_rdata  input  DW  RAM read data; asynchronous, valid in the same cycle as ram_addr.

Function
REQ-020 SHALL implement FSM states IDLE, READ, WRITE and DONE.
REQ-021 IDLE: start=1 SHALL load src_ptr<=src_addr, dst_ptr<=dst_addr and cnt<=0, then go to READ; start=0 SHALL stay in IDLE.
REQ-022 READ: SHALL drive ram_addr=src_ptr and ram_we=0, latch ram_rdata into data_reg, then go to WRITE.
REQ-023 WRITE: SHALL drive ram_addr=dst_ptr, ram_wdata=data_reg and ram_we=1.
REQ-024 WRITE: if data_reg==0 or cnt+1==MAX_WORDS, SHALL go to DONE; otherwise SHALL increment src_ptr, dst_ptr and cnt, then go to READ.
REQ-025 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-026 Each copied word SHALL take exactly 2 cycles, and the nul terminator SHALL be written.
REQ-027 For a string of N characters plus nul, done SHALL rise 2(N+1)+1 cycles after the start cycle.
REQ-028 src_ptr and dst_ptr SHALL wrap modulo 2^AW (1023+1 -> 0); cnt SHALL be AW+1 bits wide.
REQ-029 In IDLE and DONE, host_stall SHALL be 0, ram_we=host_we, ram_addr=host_addr and ram_wdata=host_wdata.
REQ-030 In READ and WRITE, host_stall SHALL be 1 and host_we SHALL be ignored, meaning no host write reaches the RAM.
REQ-031 host_rdata SHALL equal ram_rdata in every state; it is meaningful only when host_stall=0.
REQ-032 start together with host_we in IDLE: the host write SHALL occur in that cycle and the copy SHALL begin the next cycle.
REQ-033 start asserted outside IDLE SHALL be ignored and not queued.
REQ-034 Overlapping source and destination regions SHALL receive no special handling: a strictly forward word-by-word copy.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE and clear src_ptr, dst_ptr, cnt and data_reg to 0.
REQ-036 Reset SHALL force busy=0, done=0 and host_stall=0.
REQ-037 Reset during READ or WRITE SHALL abort the copy, and no RAM write SHALL occur in the reset cycle.
REQ-038 Reset SHALL take priority over start.

Configuration
REQ-039 With RAM_STRCPY_COUNT_EN defined, SHALL add output copy_count (AW+1 bits), loaded with the number of words written (terminator included) on entry to DONE, held until the next DONE, and cleared by reset.
REQ-040 Without RAM_STRCPY_COUNT_EN, the copy_count port and its register SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-041 RAM[6..8]="W","a",0; start with src=6, dst=600 -> RAM[600..602]=0x057,0x061,0x000; done pulses 7 cycles after start; copy_count=3.
REQ-042 src word =0; start with src=5, dst=700 -> one READ/WRITE pair, RAM[700]=0, done 3 cycles after start, copy_count=1.
REQ-043 src=1022, dst=100, RAM[1022]=0x041, RAM[1023]=0x042, RAM[0]=0 -> RAM[100..102]=0x041,0x042,0x000 (pointer wrap).
REQ-044 Host writes 0x3FF to address 50 while busy -> host_stall=1 and RAM[50] unchanged; the same write in IDLE -> RAM[50]=0x3FF.
REQ-045 Reset asserted in the 4th cycle of a 10-word copy -> next cycle state IDLE, busy=0, no further destination writes, done never pulses.
REQ-046 Region with no nul and MAX_WORDS=4 -> exactly 4 words written, then done.
